usb_rx_bitdec: RTL and testbench
================================

# usb_rx_bitdec

Full-speed USB receive front end for the `usb` core. It takes the raw D+/D- pad levels and recovers the 12 Mb/s bit clock from 4x oversampling at 48 MHz. It then performs NRZI decoding, bit unstuffing, SYNC and EOP detection and byte assembly. It feeds whole bytes with packet framing to the packet-level receiver, and flags a USB bus reset.

## Interface
Parameters:
- `RESET_CYCLES`, 120: number of consecutive SE0 clocks (2.5 µs at 48 MHz) that declares a bus reset.

Ports:
- `clk` in 1: 48 MHz core clock.
- `rst` in 1: reset, asynchronous and active-high.
- `pad_dp` in 1: raw D+ level, asynchronous to `clk`.
- `pad_dn` in 1: raw D- level, asynchronous to `clk`.
- `byte_data` out 8: received byte, LSB received first.
- `byte_valid` out 1: one-cycle strobe; `byte_data` is valid in that cycle.
- `pkt_start` out 1: one-cycle strobe on the cycle SYNC completes.
- `pkt_end` out 1: one-cycle strobe on the cycle EOP completes.
- `pkt_err` out 1: qualifies `pkt_end`; 1 means the packet is corrupt.
- `bus_reset` out 1: level; high while SE0 has persisted for at least `RESET_CYCLES`.

## Operation
- **Input sync:** `pad_dp` and `pad_dn` pass through a 2-FF synchroniser each. Line state is J=(1,0), K=(0,1), SE0=(0,0), SE1=(1,1).
- **Clock recovery:**
  - 2-bit phase counter; it resets to 0 on any change of synchronised line state and otherwise increments modulo 4.
  - A symbol is taken when phase == 2, giving one `sym_valid` per bit time; the nominal period is 4 clocks and 3 or 5 clocks are tolerated.
- **NRZI decode:** bit = 1 if the symbol equals the previous J/K symbol, otherwise 0. The previous symbol resets to J.
- **State machine:** IDLE, SYNC, DATA, ABORT, EOP. Reset enters IDLE.
  - **IDLE:** a K symbol moves to SYNC with the zero count = 1.
  - **SYNC:**
    - Each 0 bit increments the zero count, saturating at 7.
    - A 1 bit with zero count ≥ 3 pulses `pkt_start` and moves to DATA; the ones counter = 1, because the final SYNC 1 counts toward stuffing.
    - A 1 bit with zero count < 3, or SE0/SE1, returns to IDLE silently.
  - **DATA:**
    - Bits shift in LSB-first; after every 8 kept bits, pulse `byte_valid`.
    - Ones counter: increments on 1, clears on 0. When the counter is 6, the next bit is a stuff bit. If it is 0 it is discarded and the counter clears; if it is 1 it is a stuff error: latch the error and move to ABORT.
    - An SE1 symbol latches the error and moves to ABORT.
    - An SE0 symbol moves to EOP. If the residual bit count is nonzero, the error is latched.
  - **ABORT:** no bytes are emitted; SE0 moves to EOP.
  - **EOP:**
    - SE0 symbols are held.
    - The first J symbol pulses `pkt_end` with `pkt_err` = latched error, then clears the error and goes to IDLE.
    - A K symbol latches the error and goes to IDLE after pulsing `pkt_end`.
- **Bus reset:**
  - The SE0 counter counts clocks of synchronised SE0 and saturates at `RESET_CYCLES`; any non-SE0 clock clears it.
  - `bus_reset` is high while the counter equals `RESET_CYCLES`.
  - When `bus_reset` rises, the FSM is forced to IDLE with no `pkt_end`.
- **Simultaneous events:** the last byte's `byte_valid` and the SE0-driven transition to EOP never coincide. `pkt_end` is always at least one bit time after the last `byte_valid`.

## Timing
- **Reset values:** all outputs 0, including `byte_data`. The phase counter, ones counter, zero count and error latch are also 0.
- **Latency:**
  - Pad edge to synchronised line state: 2 clocks.
  - The symbol is taken 2 clocks after the phase reset.
  - `byte_valid` asserts 1 clock after the symbol carrying the 8th bit.
- **Strobes:** `pkt_start`, `byte_valid` and `pkt_end` are registered, single-cycle, and never asserted in the same cycle.
- **Reset mid-packet:** asynchronous `rst` clears everything immediately; no `pkt_end` is emitted for the interrupted packet.

## Structure
- Shared include `usb_defs.vh` holds:
  - line-state codes `LS_SE0`/`LS_J`/`LS_K`/`LS_SE1`;
  - FSM state encodings;
  - the constant 6 for the stuff limit.
- Sub-module `usb_rx_dpll` contains the synchroniser, line-state decode and phase counter. It outputs `sym`[1:0] and `sym_valid`. The remainder (NRZI, unstuff, FSM, byte shift register, SE0 counter) sits in `usb_rx_bitdec`.

## Test plan
- **Single byte:** idle J, then SYNC (KJKJKJKK), byte 0x69 (IN PID), SE0 for 2 bits, then J. Required: `pkt_start` once, then `byte_valid` once with 0x69, then `pkt_end`=1 with `pkt_err`=0.
- **Bit stuffing:** bytes 0xFF 0x01 sent with correct stuff bits at 4-clock bit times. Required: exactly two `byte_valid` (0xFF, 0x01) and `pkt_err`=0.
- **Stuff error:** seven consecutive 1 bits inside DATA. Required: no further `byte_valid`, then `pkt_end`=1 with `pkt_err`=1 on EOP.
- **Clock drift:** byte 0xA5 sent with bit times alternating 3 and 5 clocks. Required: 0xA5 received, `pkt_err`=0.
- **Dribble:** 12 data bits before SE0. Required: one `byte_valid`, then `pkt_err`=1 at `pkt_end`.
- **Bus reset:** SE0 held 200 clocks mid-packet. Required: `bus_reset` rises at clock 120 + 2 (sync) and falls 3 clocks after J returns; no `pkt_end`. An `rst` pulse mid-byte clears all outputs within the same cycle.

Source files
------------

// File: rtl/usb_rx_bitdec_pkg.sv
// Shared line-state codes, receive FSM encoding and framing constants for the FS USB receiver.
// Pure definitions: no latency and no flow control.
package usb_rx_bitdec_pkg;

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_DATA  = 3'd2,
        ST_ABORT = 3'd3,
        ST_EOP   = 3'd4
    } rx_state_t;

    localparam logic [2:0] STUFF_LIMIT    = 3'd6;
    localparam logic [2:0] SYNC_MIN_ZEROS = 3'd3;

endpackage

// File: rtl/usb_rx_bitdec_dpll.sv
// Pad synchroniser, line-state decode and 4x-oversampling phase tracker.
// Line state 2 clocks after a pad edge, symbol 2 clocks after phase reset; no backpressure.
module usb_rx_bitdec_dpll
    import usb_rx_bitdec_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       pad_dp,
    input  logic       pad_dn,
    output logic [1:0] line_state,
    output logic [1:0] sym,
    output logic       sym_valid
);

    logic [1:0] dp_sync_q, dp_sync_d;
    logic [1:0] dn_sync_q, dn_sync_d;
    logic [1:0] ls_prev_q, ls_prev_d;
    logic [1:0] phase_q, phase_d;

    always_comb begin
        dp_sync_d  = {dp_sync_q[0], pad_dp};
        dn_sync_d  = {dn_sync_q[0], pad_dn};
        line_state = {dp_sync_q[1], dn_sync_q[1]};
        ls_prev_d  = line_state;
        phase_d    = (line_state != ls_prev_q) ? 2'd0 : phase_q + 2'd1;
        // The delayed copy is the value the bit cell held even if a short
        // (3-clock) cell ends in the sampling cycle.
        sym        = ls_prev_q;
        sym_valid  = (phase_q == 2'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_sync_q <= 2'b00;
            dn_sync_q <= 2'b00;
            ls_prev_q <= LS_SE0;
            phase_q   <= 2'd0;
        end else begin
            dp_sync_q <= dp_sync_d;
            dn_sync_q <= dn_sync_d;
            ls_prev_q <= ls_prev_d;
            phase_q   <= phase_d;
        end
    end

endmodule

// File: rtl/usb_rx_bitdec.sv
// FS USB receive bit decoder: NRZI, unstuffing, SYNC/EOP framing, byte assembly, bus-reset detect.
// byte_valid 1 clock after the 8th-bit symbol; no backpressure, consumer must take every strobe.
module usb_rx_bitdec
    import usb_rx_bitdec_pkg::*;
#(
    parameter int RESET_CYCLES = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pad_dp,
    input  logic       pad_dn,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       pkt_start,
    output logic       pkt_end,
    output logic       pkt_err,
    output logic       bus_reset
);

    localparam int SE0_W = $clog2(RESET_CYCLES + 1);
    localparam logic [SE0_W-1:0] SE0_MAX = SE0_W'(RESET_CYCLES);

    logic [1:0] line_state;
    logic [1:0] sym;
    logic       sym_valid;

    usb_rx_bitdec_dpll u_dpll (
        .clk        (clk),
        .rst        (rst),
        .pad_dp     (pad_dp),
        .pad_dn     (pad_dn),
        .line_state (line_state),
        .sym        (sym),
        .sym_valid  (sym_valid)
    );

    rx_state_t        state_q, state_d;
    logic [1:0]       prev_jk_q, prev_jk_d;
    logic [2:0]       zero_cnt_q, zero_cnt_d;
    logic [2:0]       ones_cnt_q, ones_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             err_q, err_d;
    logic [7:0]       byte_data_q, byte_data_d;
    logic             byte_valid_q, byte_valid_d;
    logic             pkt_start_q, pkt_start_d;
    logic             pkt_end_q, pkt_end_d;
    logic             pkt_err_q, pkt_err_d;
    logic [SE0_W-1:0] se0_cnt_q, se0_cnt_d;

    logic is_jk;
    logic bit_val;

    assign bus_reset = (se0_cnt_q == SE0_MAX);

    always_comb begin
        if (line_state != LS_SE0) begin
            se0_cnt_d = '0;
        end else if (se0_cnt_q == SE0_MAX) begin
            se0_cnt_d = se0_cnt_q;
        end else begin
            se0_cnt_d = se0_cnt_q + SE0_W'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        prev_jk_d    = prev_jk_q;
        zero_cnt_d   = zero_cnt_q;
        ones_cnt_d   = ones_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        err_d        = err_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        pkt_start_d  = 1'b0;
        pkt_end_d    = 1'b0;
        pkt_err_d    = 1'b0;

        is_jk   = (sym == LS_J) || (sym == LS_K);
        bit_val = (sym == prev_jk_q);

        if (sym_valid) begin
            if (is_jk) begin
                prev_jk_d = sym;
            end
            case (state_q)
                ST_IDLE: begin
                    if (sym == LS_K) begin
                        state_d    = ST_SYNC;
                        zero_cnt_d = 3'd1;
                    end
                end
                ST_SYNC: begin
                    if (!is_jk) begin
                        state_d = ST_IDLE;
                    end else if (!bit_val) begin
                        if (zero_cnt_q != 3'd7) begin
                            zero_cnt_d = zero_cnt_q + 3'd1;
                        end
                    end else if (zero_cnt_q >= SYNC_MIN_ZEROS) begin
                        // The closing SYNC 1 already counts toward the stuffing run.
                        pkt_start_d = 1'b1;
                        state_d     = ST_DATA;
                        ones_cnt_d  = 3'd1;
                        bit_cnt_d   = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (sym == LS_SE0) begin
                        state_d = ST_EOP;
                        if (bit_cnt_q != 3'd0) begin
                            err_d = 1'b1;
                        end
                    end else if (sym == LS_SE1) begin
                        err_d   = 1'b1;
                        state_d = ST_ABORT;
                    end else if (ones_cnt_q == STUFF_LIMIT) begin
                        if (bit_val) begin
                            err_d   = 1'b1;
                            state_d = ST_ABORT;
                        end else begin
                            ones_cnt_d = 3'd0;
                        end
                    end else begin
                        ones_cnt_d = bit_val ? ones_cnt_q + 3'd1 : 3'd0;
                        shift_d    = {bit_val, shift_q[7:1]};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_valid_d = 1'b1;
                            byte_data_d  = shift_d;
                        end
                    end
                end
                ST_ABORT: begin
                    if (sym == LS_SE0) begin
                        state_d = ST_EOP;
                    end
                end
                ST_EOP: begin
                    if (sym == LS_J) begin
                        pkt_end_d = 1'b1;
                        pkt_err_d = err_q;
                        err_d     = 1'b0;
                        state_d   = ST_IDLE;
                    end else if (sym == LS_K) begin
                        pkt_end_d = 1'b1;
                        pkt_err_d = 1'b1;
                        err_d     = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A held bus reset abandons any frame silently; SE0 cannot produce strobes here.
        if (bus_reset) begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            prev_jk_q    <= LS_J;
            zero_cnt_q   <= 3'd0;
            ones_cnt_q   <= 3'd0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            err_q        <= 1'b0;
            byte_data_q  <= 8'h00;
            byte_valid_q <= 1'b0;
            pkt_start_q  <= 1'b0;
            pkt_end_q    <= 1'b0;
            pkt_err_q    <= 1'b0;
            se0_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            prev_jk_q    <= prev_jk_d;
            zero_cnt_q   <= zero_cnt_d;
            ones_cnt_q   <= ones_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            err_q        <= err_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            pkt_start_q  <= pkt_start_d;
            pkt_end_q    <= pkt_end_d;
            pkt_err_q    <= pkt_err_d;
            se0_cnt_q    <= se0_cnt_d;
        end
    end

    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign pkt_start  = pkt_start_q;
    assign pkt_end    = pkt_end_q;
    assign pkt_err    = pkt_err_q;

endmodule

// File: tb/tb_usb_rx_bitdec.sv
// Directed bench for usb_rx_bitdec: NRZI/stuffing line driver plus an event scoreboard.
// Expected framing events are queued ahead of stimulus and popped by a negedge monitor.
module tb_usb_rx_bitdec;
    import usb_rx_bitdec_pkg::*;

    localparam logic [1:0] EV_START = 2'd1;
    localparam logic [1:0] EV_BYTE  = 2'd2;
    localparam logic [1:0] EV_END   = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] dat;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       pad_dp;
    logic       pad_dn;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       pkt_start;
    logic       pkt_end;
    logic       pkt_err;
    logic       bus_reset;

    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    logic [1:0] cur_ls = LS_J;
    int   tx_ones = 0;
    bit   drift = 1'b0;
    bit   alt = 1'b0;

    usb_rx_bitdec #(.RESET_CYCLES(120)) dut (
        .clk        (clk),
        .rst        (rst),
        .pad_dp     (pad_dp),
        .pad_dn     (pad_dn),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .pkt_start  (pkt_start),
        .pkt_end    (pkt_end),
        .pkt_err    (pkt_err),
        .bus_reset  (bus_reset)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic int bit_len();
        if (drift) begin
            alt = ~alt;
            return alt ? 3 : 5;
        end
        return 4;
    endfunction

    task automatic drive(input logic [1:0] ls, input int n);
        pad_dp = ls[1];
        pad_dn = ls[0];
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_raw(input logic b);
        if (!b) cur_ls = (cur_ls == LS_J) ? LS_K : LS_J;
        drive(cur_ls, bit_len());
    endtask

    task automatic send_data_bit(input logic b);
        send_raw(b);
        if (b) begin
            tx_ones++;
            if (tx_ones == 6) begin
                send_raw(1'b0);
                tx_ones = 0;
            end
        end else begin
            tx_ones = 0;
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [7:0] dat);
        ev_t e;
        e.kind = kind;
        e.dat  = dat;
        exp_q.push_back(e);
    endtask

    task automatic send_sync();
        push(EV_START, 8'h00);
        repeat (7) send_raw(1'b0);
        send_raw(1'b1);
        tx_ones = 1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        push(EV_BYTE, v);
        for (int i = 0; i < 8; i++) send_data_bit(v[i]);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) send_data_bit(v[i]);
    endtask

    task automatic idle_bits(input int n);
        cur_ls = LS_J;
        drive(LS_J, 4 * n);
    endtask

    task automatic send_eop(input logic err);
        int n;
        push(EV_END, {7'b0, err});
        n = bit_len();
        n = n + bit_len();
        drive(LS_SE0, n);
        cur_ls = LS_J;
        drive(LS_J, bit_len());
        idle_bits(4);
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    initial begin
        ev_t act;
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst && (pkt_start || byte_valid || pkt_end)) begin
                if ((32'(pkt_start) + 32'(byte_valid) + 32'(pkt_end)) > 1) begin
                    checks++;
                    errors++;
                    $display("FAIL strobe_overlap: got start=%0b byte=%0b end=%0b, expected one", pkt_start, byte_valid, pkt_end);
                end
                act.kind = pkt_start ? EV_START : (byte_valid ? EV_BYTE : EV_END);
                act.dat  = byte_valid ? byte_data : (pkt_end ? {7'b0, pkt_err} : 8'h00);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got kind=%0d dat=%h, expected none", act.kind, act.dat);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL event: got kind=%0d dat=%h, expected kind=%0d dat=%h", act.kind, act.dat, e.kind, e.dat);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        pad_dp = 1'b1;
        pad_dn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_byte_data", byte_data, 8'h00);
        check("rst_byte_valid", {7'b0, byte_valid}, 8'h00);
        check("rst_pkt_start", {7'b0, pkt_start}, 8'h00);
        check("rst_pkt_end", {7'b0, pkt_end}, 8'h00);
        check("rst_pkt_err", {7'b0, pkt_err}, 8'h00);
        check("rst_bus_reset", {7'b0, bus_reset}, 8'h00);
        @(posedge clk);
        #2;
        rst = 1'b0;
        idle_bits(10);

        // Single IN PID.
        send_sync();
        send_byte(8'h69);
        send_eop(1'b0);
        idle_bits(4);

        // Stuff bit after the sixth consecutive 1 (SYNC's final 1 counts).
        send_sync();
        send_byte(8'hFF);
        send_byte(8'h01);
        send_eop(1'b0);
        idle_bits(4);

        // Seven raw 1s: stuff violation, no further bytes.
        send_sync();
        send_byte(8'h00);
        repeat (7) send_raw(1'b1);
        send_eop(1'b1);
        idle_bits(4);

        // Bit cells alternating 3 and 5 clocks.
        drift = 1'b1;
        alt   = 1'b0;
        send_sync();
        send_byte(8'hA5);
        send_eop(1'b0);
        drift = 1'b0;
        idle_bits(4);

        // Dribble: 12 data bits.
        send_sync();
        send_byte(8'h69);
        send_bits(8'h0A, 4);
        send_eop(1'b1);
        idle_bits(4);

        // Bus reset mid-byte: SE0 held for 200 clocks, no pkt_end.
        send_sync();
        send_byte(8'h69);
        send_bits(8'h05, 3);
        pad_dp = 1'b0;
        pad_dn = 1'b0;
        repeat (121) @(posedge clk);
        @(negedge clk);
        check("bus_reset_before_122", {7'b0, bus_reset}, 8'h00);
        @(posedge clk);
        @(negedge clk);
        check("bus_reset_at_122", {7'b0, bus_reset}, 8'h01);
        repeat (78) @(posedge clk);
        #2;
        cur_ls = LS_J;
        pad_dp = 1'b1;
        pad_dn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bus_reset_hold_2", {7'b0, bus_reset}, 8'h01);
        @(posedge clk);
        @(negedge clk);
        check("bus_reset_fall_3", {7'b0, bus_reset}, 8'h00);
        @(posedge clk);
        #2;
        idle_bits(8);

        // Clean packet after the bus reset: error latch must be clear.
        send_sync();
        send_byte(8'hC3);
        send_eop(1'b0);
        idle_bits(4);

        // Asynchronous rst mid-byte.
        send_sync();
        send_byte(8'h69);
        send_bits(8'h05, 3);
        check("byte_data_before_rst", byte_data, 8'h69);
        #5;
        rst = 1'b1;
        #1;
        check("rst_async_byte_data", byte_data, 8'h00);
        check("rst_async_strobes", {5'b0, byte_valid, pkt_start, pkt_end}, 8'h00);
        check("rst_async_err_busrst", {6'b0, pkt_err, bus_reset}, 8'h00);
        cur_ls = LS_J;
        pad_dp = 1'b1;
        pad_dn = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        idle_bits(10);

        check("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
